// File: rtl/nes_multi_pad_reader_if.sv
// Event stream from the pad reader (master) to its consumer (slave).
// A head event is offered while event_valid is high and is taken on
// event_valid & event_ready. event_drop is a one-cycle loss indicator.
interface nes_multi_pad_reader_if;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_pad;
  logic [3:0] event_code;
  logic       event_drop;

  modport master (
    output event_valid,
    output event_pad,
    output event_code,
    output event_drop,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_pad,
    input  event_code,
    input  event_drop,
    output event_ready
  );
endinterface

// File: rtl/nes_multi_pad_reader.sv
// Polls up to four NES controllers in parallel once per frame over a shared
// latch/pulse pair, publishes the held button state, and turns fresh presses
// and auto-repeats of selected buttons into a small event queue.
// FIFO_DEPTH must be a power of two and at least 2.
module nes_multi_pad_reader #(
  parameter int          NUM_PADS      = 2,
  parameter int          PERIOD_CYCLES = 833334,
  parameter int          HALF_BIT      = 300,
  parameter logic [7:0]  REPEAT_MASK   = 8'hE0,
  parameter int          REPEAT_DELAY  = 20,
  parameter int          REPEAT_RATE   = 6,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PADS-1:0]   nes_data,
  output logic                  nes_latch,
  output logic                  nes_pulse,
  output logic [8*NUM_PADS-1:0] buttons,
  nes_multi_pad_reader_if.master ev
);

  localparam int H            = HALF_BIT;
  localparam int CNT_W        = $clog2(PERIOD_CYCLES);
  localparam int LATCH_END    = 2 * H;
  localparam int FIRST_SAMPLE = 3 * H;
  localparam int LAST_SAMPLE  = 3 * H + 14 * H;
  localparam int HOLD_W       = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W       = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE + 1) : 1;
  localparam int AW           = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_LATCH,
    ST_SHIFT,
    ST_COMMIT,
    ST_SCAN
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   frame_cnt;
  logic               sample_hit;
  logic               pulse_on;
  logic [1:0]         scan_idx;

  logic [7:0]         shreg    [NUM_PADS];
  logic [7:0]         btn      [NUM_PADS];
  logic [7:0]         prev     [NUM_PADS];
  logic [HOLD_W-1:0]  hold_cnt [NUM_PADS];
  logic [RATE_W-1:0]  rate_cnt [NUM_PADS];
  logic [NUM_PADS-1:0] rep_due;
  logic [7:0]         masked_new [NUM_PADS];
  logic [7:0]         masked_old [NUM_PADS];

  logic [7:0]         sel_btn, sel_prev, new_press, held_masked;
  logic               sel_due;
  logic               push;
  logic [3:0]         push_code;

  logic [5:0]         mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr, fifo_count;
  logic               fifo_empty, fifo_full, pop, do_push, drop, drop_q;

  // Code of the lowest set bit (k+1), or 0 for an empty vector.
  function automatic logic [3:0] first_code(input logic [7:0] v);
    first_code = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) first_code = 4'(k + 1);
    end
  endfunction

  // Frame timebase: free-running 0..PERIOD_CYCLES-1.
  // NOTE: clocked state is always written with <= so every register samples
  // the pre-edge values of its peers; = here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else if (frame_cnt == CNT_W'(PERIOD_CYCLES - 1)) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + 1'b1;
  end

  // Decode sample instants and pulse-high windows from the frame position.
  // NOTE: every signal driven here gets a default before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sample_hit = 1'b0;
    pulse_on   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (frame_cnt == CNT_W'(FIRST_SAMPLE + 2 * H * k)) sample_hit = 1'b1;
      if (frame_cnt >= CNT_W'(FIRST_SAMPLE + 2 * H * k + 1) &&
          frame_cnt <= CNT_W'(FIRST_SAMPLE + 2 * H * k + H)) pulse_on = 1'b1;
    end
  end

  // Registered pad strobes, one cycle behind frame_cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nes_latch <= 1'b0;
      nes_pulse <= 1'b0;
    end else begin
      nes_latch <= (frame_cnt < CNT_W'(LATCH_END));
      nes_pulse <= pulse_on;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_WAIT;
    else       state <= state_nxt;
  end

  // Sequencer next-state: latch, shift in 8 bits, commit, scan each pad.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:   if (frame_cnt == '0) state_nxt = ST_LATCH;
      ST_LATCH:  if (frame_cnt == CNT_W'(LATCH_END)) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (frame_cnt == CNT_W'(LAST_SAMPLE)) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_SCAN;
      ST_SCAN:   if (scan_idx == 2'(NUM_PADS - 1)) state_nxt = ST_WAIT;
      default:   state_nxt = ST_WAIT;
    endcase
  end

  // Pad index walked during SCAN, one pad per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   scan_idx <= '0;
    else if (state == ST_COMMIT) scan_idx <= '0;
    else if (state == ST_SCAN)   scan_idx <= scan_idx + 1'b1;
  end

  // Masked held sets, new (shift register) versus currently published.
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      masked_new[p] = shreg[p] & REPEAT_MASK;
      masked_old[p] = btn[p] & REPEAT_MASK;
    end
  end

  // Per-pad capture, commit and auto-repeat timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        shreg[p]    <= '0;
        btn[p]      <= '0;
        prev[p]     <= '0;
        hold_cnt[p] <= '0;
        rate_cnt[p] <= '0;
      end
      rep_due <= '0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        // First sample is button A; shifting right leaves it in bit 0.
        if (state == ST_SHIFT && sample_hit)
          shreg[p] <= {~nes_data[p], shreg[p][7:1]};
        if (state == ST_COMMIT) begin
          btn[p]  <= shreg[p];
          prev[p] <= btn[p];
          if (masked_new[p] == '0 || masked_new[p] != masked_old[p]) begin
            hold_cnt[p] <= '0;
            rate_cnt[p] <= '0;
            rep_due[p]  <= 1'b0;
          end else if (hold_cnt[p] != HOLD_W'(REPEAT_DELAY)) begin
            // Still in the initial delay; the first repeat fires on arrival.
            hold_cnt[p] <= hold_cnt[p] + 1'b1;
            rep_due[p]  <= (hold_cnt[p] == HOLD_W'(REPEAT_DELAY - 1));
            rate_cnt[p] <= RATE_W'(REPEAT_RATE - 1);
          end else if (rate_cnt[p] == '0) begin
            rep_due[p]  <= 1'b1;
            rate_cnt[p] <= RATE_W'(REPEAT_RATE - 1);
          end else begin
            rep_due[p]  <= 1'b0;
            rate_cnt[p] <= rate_cnt[p] - 1'b1;
          end
        end
      end
    end
  end

  // Publish held state as a flat vector.
  always_comb begin
    buttons = '0;
    for (int p = 0; p < NUM_PADS; p++) buttons[8*p +: 8] = btn[p];
  end

  // Event selection for the pad being scanned: new press beats repeat.
  always_comb begin
    sel_btn  = '0;
    sel_prev = '0;
    sel_due  = 1'b0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (scan_idx == 2'(p)) begin
        sel_btn  = btn[p];
        sel_prev = prev[p];
        sel_due  = rep_due[p];
      end
    end
    new_press   = sel_btn & ~sel_prev;
    held_masked = sel_btn & REPEAT_MASK;
    push        = 1'b0;
    push_code   = '0;
    if (state == ST_SCAN) begin
      if (new_press != '0) begin
        push      = 1'b1;
        push_code = first_code(new_press);
      end else if (sel_due && held_masked != '0) begin
        push      = 1'b1;
        push_code = first_code(held_masked);
      end
    end
  end

  // FIFO bookkeeping: a full FIFO still accepts a push when it pops the same cycle.
  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign pop        = ~fifo_empty & ev.event_ready;
  assign do_push    = push & (~fifo_full | pop);
  assign drop       = push & fifo_full & ~pop;

  // FIFO pointers and registered drop strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      drop_q <= drop;
    end
  end

  // FIFO storage.
  // NOTE: the entry array has no reset; pointers define validity and an empty
  // FIFO masks the head, so clearing storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {scan_idx, push_code};
  end

  assign ev.event_valid = ~fifo_empty;
  assign ev.event_pad   = fifo_empty ? 2'd0 : mem[rd_ptr[AW-1:0]][5:4];
  assign ev.event_code  = fifo_empty ? 4'd0 : mem[rd_ptr[AW-1:0]][3:0];
  assign ev.event_drop  = drop_q;

endmodule

// File: tb/tb_nes_multi_pad_reader.sv
// Self-checking bench: emulated NES pads, a frame-level reference model feeding
// an expected-event queue, and an independent monitor comparing each head event.
module tb_nes_multi_pad_reader;

  localparam int         NUM_PADS = 2;
  localparam int         PERIOD   = 120;
  localparam int         H        = 4;
  localparam int         DELAY    = 3;
  localparam int         RATE     = 2;
  localparam int         DEPTH    = 4;
  localparam logic [7:0] MASK     = 8'hE0;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_PADS-1:0]   nes_data;
  logic                  nes_latch;
  logic                  nes_pulse;
  logic [8*NUM_PADS-1:0] buttons;

  nes_multi_pad_reader_if ev_if ();

  nes_multi_pad_reader #(
    .NUM_PADS      (NUM_PADS),
    .PERIOD_CYCLES (PERIOD),
    .HALF_BIT      (H),
    .REPEAT_MASK   (MASK),
    .REPEAT_DELAY  (DELAY),
    .REPEAT_RATE   (RATE),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_pulse (nes_pulse),
    .buttons   (buttons),
    .ev        (ev_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pad;
    logic [3:0] code;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   drop_seen = 0;
  int   exp_drops = 0;

  logic [7:0] pressed [NUM_PADS];
  logic [7:0] snap    [NUM_PADS];
  int         pad_idx;

  logic [7:0] m_prev [NUM_PADS];
  logic [7:0] m_mask [NUM_PADS];
  int         m_run  [NUM_PADS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
  endtask

  // Pad emulation: snapshot on latch, advance one button per shift pulse.
  always @(posedge nes_latch) begin
    snap[0] = pressed[0];
    snap[1] = pressed[1];
    pad_idx = 0;
  end
  always @(posedge nes_pulse) pad_idx++;
  assign nes_data[0] = (pad_idx < 8) ? ~snap[0][pad_idx[2:0]] : 1'b1;
  assign nes_data[1] = (pad_idx < 8) ? ~snap[1][pad_idx[2:0]] : 1'b1;

  function automatic int lowest(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NUM_PADS; p++) begin
      m_prev[p] = '0;
      m_mask[p] = '0;
      m_run[p]  = 0;
    end
  endtask

  // One frame of the reference: run = frames the nonzero masked set has been
  // unchanged; repeats fall on run = DELAY, DELAY+RATE, DELAY+2*RATE, ...
  task automatic model_frame(input logic [7:0] p0, input logic [7:0] p1);
    logic [7:0] cur [NUM_PADS];
    cur[0] = p0;
    cur[1] = p1;
    for (int p = 0; p < NUM_PADS; p++) begin
      logic [7:0] np, ms;
      int         code;
      bit         due;
      ev_t        e;
      np = cur[p] & ~m_prev[p];
      ms = cur[p] & MASK;
      if (ms == '0 || ms != m_mask[p]) m_run[p] = 0;
      else m_run[p]++;
      due  = (ms != '0) && (m_run[p] >= DELAY) && (((m_run[p] - DELAY) % RATE) == 0);
      code = 0;
      if (np != '0) code = lowest(np) + 1;
      else if (due) code = lowest(ms) + 1;
      if (code != 0) begin
        if (exp_q.size() >= DEPTH) exp_drops++;
        else begin
          e.pad  = 2'(p);
          e.code = 4'(code);
          exp_q.push_back(e);
        end
      end
      m_prev[p] = cur[p];
      m_mask[p] = ms;
    end
  endtask

  // Monitor: compare the head against the expected queue every cycle.
  always @(negedge clk) begin
    if (ev_if.event_drop) drop_seen++;
    if (ev_if.event_valid) begin
      check("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("event_pad", 32'(ev_if.event_pad), 32'(exp_q[0].pad));
        check("event_code", 32'(ev_if.event_code), 32'(exp_q[0].code));
        if (ev_if.event_ready) void'(exp_q.pop_front());
      end
    end else begin
      check("empty_code", 32'(ev_if.event_code), 32'd0);
      check("empty_pad", 32'(ev_if.event_pad), 32'd0);
    end
  end

  task automatic wait_latch_rise();
    logic last;
    bit   seen;
    last = nes_latch;
    seen = 1'b0;
    for (int c = 0; c < 2 * PERIOD && !seen; c++) begin
      @(negedge clk);
      if (nes_latch && !last) seen = 1'b1;
      last = nes_latch;
    end
    check("latch_rise_seen", 32'(seen), 32'd1);
  endtask

  task automatic set_ready(input bit r);
    @(posedge clk);
    #1 ev_if.event_ready = r;
  endtask

  // Present one frame of button state, optionally measure the strobe waveform,
  // then check the published held state after the commit.
  task automatic run_frame(input logic [7:0] p0, input logic [7:0] p1, input bit measure);
    pressed[0] = p0;
    pressed[1] = p1;
    model_frame(p0, p1);
    wait_latch_rise();
    if (measure) begin
      int   lat, pul, hi, lo, bad, first_rise;
      logic pp;
      lat = 1; pul = 0; hi = 0; lo = 0; bad = 0; first_rise = -1; pp = 1'b0;
      for (int c = 0; c < 110; c++) begin
        @(negedge clk);
        if (nes_latch) lat++;
        if (nes_pulse) begin
          if (!pp && first_rise < 0) first_rise = c;
          if (!pp && pul > 0 && lo != H) bad++;
          hi++;
        end else begin
          if (pp) begin
            pul++;
            if (hi != H) bad++;
            hi = 0;
            lo = 0;
          end
          lo++;
        end
        pp = nes_pulse;
      end
      check("latch_high_cycles", 32'(lat), 32'(2 * H));
      check("pulse_count", 32'(pul), 32'd8);
      check("pulse_shape_errors", 32'(bad), 32'd0);
      check("first_pulse_offset", 32'(first_rise), 32'(3 * H));
    end else begin
      repeat (90) @(negedge clk);
    end
    check("buttons", 32'(buttons), {16'd0, p1, p0});
  endtask

  initial begin
    logic [7:0] r0, r1;
    reset              = 1'b1;
    ev_if.event_ready  = 1'b1;
    pressed[0] = '0; pressed[1] = '0;
    snap[0]    = '0; snap[1]    = '0;
    pad_idx    = 8;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_latch", 32'(nes_latch), 32'd0);
    check("rst_pulse", 32'(nes_pulse), 32'd0);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_valid", 32'(ev_if.event_valid), 32'd0);
    reset = 1'b0;

    // Idle pads: strobe waveform, no buttons, no events.
    run_frame(8'h00, 8'h00, 1'b1);
    run_frame(8'h00, 8'h00, 1'b0);

    // Pad 1 presses and holds Start: one event only.
    repeat (3) run_frame(8'h00, 8'h08, 1'b0);
    run_frame(8'h00, 8'h00, 1'b0);
    check("queue_after_start", 32'(exp_q.size()), 32'd0);

    // Pad 0 holds Left: initial press plus repeats.
    repeat (8) run_frame(8'h40, 8'h00, 1'b0);
    run_frame(8'h00, 8'h00, 1'b0);
    check("queue_after_left", 32'(exp_q.size()), 32'd0);

    // A and B in the same frame: only A reported.
    run_frame(8'h03, 8'h00, 1'b0);
    run_frame(8'h00, 8'h00, 1'b0);

    // Stalled consumer: four queued, fifth dropped, head stable.
    set_ready(1'b0);
    run_frame(8'h01, 8'h00, 1'b0);
    run_frame(8'h02, 8'h00, 1'b0);
    run_frame(8'h04, 8'h00, 1'b0);
    run_frame(8'h08, 8'h00, 1'b0);
    run_frame(8'h01, 8'h00, 1'b0);
    check("drops_while_stalled", 32'(drop_seen), 32'(exp_drops));
    check("valid_while_stalled", 32'(ev_if.event_valid), 32'd1);
    set_ready(1'b1);
    run_frame(8'h00, 8'h00, 1'b0);
    check("queue_after_drain", 32'(exp_q.size()), 32'd0);

    // Randomised held patterns, biased toward holding to exercise repeats.
    r0 = '0;
    r1 = '0;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 1) == 0)
        r0 = 8'($urandom) & (($urandom_range(0, 1) == 0) ? MASK : 8'hFF);
      if ($urandom_range(0, 2) == 0)
        r1 = 8'($urandom) & (($urandom_range(0, 1) == 0) ? MASK : 8'hFF);
      run_frame(r0, r1, 1'b0);
    end
    run_frame(8'h00, 8'h00, 1'b0);
    check("queue_after_random", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with Right held: immediate clear, no event, clean restart.
    run_frame(8'h80, 8'h00, 1'b0);
    wait_latch_rise();
    repeat (49) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_latch", 32'(nes_latch), 32'd0);
    check("midrst_pulse", 32'(nes_pulse), 32'd0);
    check("midrst_buttons", 32'(buttons), 32'd0);
    check("midrst_valid", 32'(ev_if.event_valid), 32'd0);
    check("midrst_code", 32'(ev_if.event_code), 32'd0);
    check("midrst_drop", 32'(ev_if.event_drop), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    model_frame(8'h80, 8'h00);
    #2 reset = 1'b0;
    @(posedge clk);
    #1 check("latch_after_release", 32'(nes_latch), 32'd1);
    repeat (90) @(negedge clk);
    check("buttons_after_reset", 32'(buttons), 32'h0080);
    run_frame(8'h00, 8'h00, 1'b0);
    check("queue_final", 32'(exp_q.size()), 32'd0);
    check("drop_total", 32'(drop_seen), 32'(exp_drops));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nes_multi_pad_reader.md
NES_MULTI_PAD_READER -- requirements
Module: nes_multi_pad_reader

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2: number of controllers polled in parallel (1..4).
REQ-002 SHALL have parameter PERIOD_CYCLES, default 833334: frame period in clk cycles (60 Hz at 50 MHz).
REQ-003 SHALL have parameter HALF_BIT, default 300: half-bit time in cycles (6 us at 50 MHz); PERIOD_CYCLES > 20*HALF_BIT.
REQ-004 SHALL have parameter REPEAT_MASK, default 8'hE0: buttons eligible for auto-repeat (Down, Left, Right).
REQ-005 SHALL have parameter REPEAT_DELAY, default 20: held frames before the first repeat (>=1).
REQ-006 SHALL have parameter REPEAT_RATE, default 6: frames between subsequent repeats (>=1).
REQ-007 SHALL have parameter FIFO_DEPTH, default 4: event queue entries (power of 2).
REQ-008 clk  in  1  single system clock.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 nes_data  in  NUM_PADS  serial data per pad, active-low (0 = pressed).
REQ-011 nes_latch  out  1  latch shared by all pads.
REQ-012 nes_pulse  out  1  shift clock shared by all pads.
REQ-013 buttons  out  8*NUM_PADS  held state, active-high; bit 8p+k = pad p, button k (A,B,Select,Start,Up,Down,Left,Right = k 0..7).
REQ-014 event_valid  out  1  FIFO head valid.
REQ-015 event_ready  in  1  consumer accepts head.
REQ-016 event_pad  out  2  pad index of head event.
REQ-017 event_code  out  4  button code k+1 (1..8); 0 when no event.
REQ-018 event_drop  out  1  one-cycle pulse when an event is lost to a full FIFO.

Function
REQ-019 frame_cnt SHALL count 0..PERIOD_CYCLES-1 and wrap to 0.
REQ-020 nes_latch SHALL be high for frame_cnt in [0, 2H), H = HALF_BIT; all outputs registered, one cycle behind frame_cnt.
REQ-021 For k = 0..7, each nes_data bit SHALL be sampled at frame_cnt = 3H + 2H*k into per-pad shift registers, inverted to active-high.
REQ-022 nes_pulse SHALL be high for frame_cnt in [3H+2H*k+1, 3H+2H*k+H] for k = 0..7 (8 pulses, 2H period, 50% duty).
REQ-023 FSM states: WAIT, LATCH, SHIFT, COMMIT, SCAN; WAIT->LATCH at frame_cnt=0; LATCH->SHIFT at 2H; SHIFT->COMMIT after sample k=7; COMMIT->SCAN after one cycle; SCAN->WAIT after NUM_PADS cycles.
REQ-024 COMMIT SHALL copy shift registers to buttons and save previous state; new_press = new & ~prev.
REQ-025 Per pad, hold_cnt SHALL clear at COMMIT when masked held set (buttons & REPEAT_MASK) changes or is zero, else increment, saturating at REPEAT_DELAY.
REQ-026 Repeat SHALL be due at the frame hold_cnt reaches REPEAT_DELAY, then every REPEAT_RATE frames via a reload countdown while the masked set stays unchanged.
REQ-027 In SCAN, pad p at cycle p SHALL push at most one event: lowest-index new_press bit; else, if repeat due, lowest-index held masked bit; else nothing.
REQ-028 Push when FIFO full and no same-cycle pop SHALL discard the event and pulse event_drop; push and pop same cycle when full SHALL both succeed.
REQ-029 Head SHALL hold stable while event_valid=1 and event_ready=0; pop on event_valid & event_ready.
REQ-030 event_code and event_pad SHALL read 0 when FIFO empty.
REQ-031 A pad with nes_data held high (unplugged) SHALL read all buttons 0 and produce no events.

Reset
REQ-032 Reset SHALL asynchronously clear frame_cnt, FSM to WAIT, shift regs, buttons, prev state, hold/rate counters, FIFO pointers, and all outputs to 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame without commit; first nes_latch rises one cycle after release.

Verification (H=4, PERIOD_CYCLES=120, REPEAT_DELAY=3, REPEAT_RATE=2, FIFO_DEPTH=4)
REQ-034 No pads pressed -> nes_latch high 8 cycles, 8 pulses of 4 high/4 low, buttons=0, event_valid=0.
REQ-035 Pad1 presses Start (bit 3 low) -> buttons[11]=1, one event pad=1 code=4; nothing on following frames while held.
REQ-036 Pad0 holds Left for 8 frames, ready=1 -> code 7 events at frames 0, 3, 5, 7.
REQ-037 Pad0 A+B new same frame -> single event code 1; B not reported.
REQ-038 event_ready=0, new presses over 5 frames -> 4 events queued in order, 5th raises event_drop for 1 cycle, head unchanged.
REQ-039 Reset asserted at frame_cnt=50 with Right pressed -> outputs 0 immediately, no event, normal latch after release.
